store_buffer: RTL and testbench

- Posted-write buffer between the core memory stage and the data memory block.
- Stores are accepted without stalling the core and drained in order to data memory.
- Loads go to data memory ahead of pending stores unless they hit a buffered word, in which case they wait for the drain.
- Mem-side outputs drive data memory's addr/write_data/memwrite/memread/sign_mask; mem_stall is its clk_stall.

---
 rtl/store_buffer_pkg.sv | 32 +++
 rtl/store_buffer_sb_fifo.sv | 79 +++++++
 rtl/store_buffer.sv | 156 +++++++++++++++
 tb/tb_store_buffer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer slice.
//   - mem-side FSM state encoding
//   - FIFO payload layout and width (addr + wdata + sign_mask = 68 bits;
//     the valid bit is kept beside the payload in the FIFO)
//   - sign_mask size codes used by the data memory
//   - word-address compare helper used by the hazard match
package store_buffer_pkg;

  typedef enum logic [1:0] {
    M_IDLE  = 2'd0,
    M_ISSUE = 2'd1,
    M_WAIT  = 2'd2
  } mem_state_e;

  localparam int ENTRY_W = 68;

  localparam logic [3:0] SM_BYTE = 4'b0001;
  localparam logic [3:0] SM_HALF = 4'b0011;
  localparam logic [3:0] SM_WORD = 4'b1111;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sign_mask;
  } sb_payload_t;

  // Two byte addresses hit the same 32-bit word (caller passes addr[31:2]).
  function automatic logic word_match(input logic [29:0] word_a, input logic [29:0] word_b);
    return (word_a == word_b);
  endfunction

endpackage

// File: rtl/store_buffer_sb_fifo.sv
// sb_fifo: circular store FIFO for the store buffer.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, push_data   write an entry at the tail
//   pop               retire the entry at the head
//   head_data         payload at the head (valid when count != 0)
//   count, full       occupancy and full flag
//   match_word        word address (addr[31:2]) to compare
//   match             some valid entry holds that word address
// A push and a pop in the same cycle keep count unchanged; when full the
// pushed entry lands in the slot that the pop frees.
module sb_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  sb_payload_t       push_data,
  input  logic              pop,
  output sb_payload_t       head_data,
  output logic [PTR_W:0]    count,
  output logic              full,
  input  logic [29:0]       match_word,
  output logic              match
);

  sb_payload_t         entry_r [DEPTH];
  logic [DEPTH-1:0]    valid_r;
  logic [PTR_W-1:0]    head_r;
  logic [PTR_W-1:0]    tail_r;
  logic [PTR_W:0]      count_r;
  logic                match_s;

  // Entry storage, valid bits, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i] <= '0;
      end
      valid_r <= '0;
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (pop) begin
        valid_r[head_r] <= 1'b0;
        head_r          <= head_r + 1'b1;
      end
      // Placed after the pop so a full push+pop on the same slot stays valid.
      if (push) begin
        entry_r[tail_r] <= push_data;
        valid_r[tail_r] <= 1'b1;
        tail_r          <= tail_r + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Word-address match over every valid entry (load hazard detection).
  always_comb begin
    match_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      match_s = match_s | (valid_r[i] & word_match(entry_r[i].addr[31:2], match_word));
    end
  end

  assign match     = match_s;
  assign head_data = entry_r[head_r];
  assign count     = count_r;
  assign full      = (count_r == (PTR_W + 1)'(DEPTH));

endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer between the core memory stage and data
// memory. Stores are queued in sb_fifo and drained in order; loads bypass
// queued stores unless they hit a buffered word.
// Ports:
//   core_*  request side from the memory stage; core_stall holds the core,
//           core_rdata returns load data (held until the next load completes)
//   mem_*   request side to data memory; mem_memwrite/mem_memread are
//           one-cycle strobes, mem_stall is the data memory busy flag
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic        core_memwrite,
  input  logic        core_memread,
  input  logic [3:0]  core_sign_mask,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_stall
);

  mem_state_e   state_r, state_next_s;
  logic         op_store_r;     // in-flight op is a store (else a load)
  logic         seen_stall_r;   // mem_stall observed high for the current op
  logic         load_done_r;    // core_rdata was captured on the previous cycle
  logic [31:0]  mem_addr_r, mem_wdata_r, core_rdata_r;
  logic [3:0]   mem_sign_mask_r;
  logic         mem_memwrite_r, mem_memread_r;

  sb_payload_t  push_data_s, head_s;
  logic [PTR_W:0] count_s;
  logic         full_s, match_s, push_s, pop_s, done_s;
  logic         load_req_s, sel_load_s, sel_store_s, core_stall_s;

  sb_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_s),
    .push_data  (push_data_s),
    .pop        (pop_s),
    .head_data  (head_s),
    .count      (count_s),
    .full       (full_s),
    .match_word (core_addr[31:2]),
    .match      (match_s)
  );

  // Completion, push/pop and core-side stall.
  always_comb begin
    push_data_s = '{addr: core_addr, wdata: core_wdata, sign_mask: core_sign_mask};
    done_s      = (state_r == M_WAIT) && seen_stall_r && !mem_stall;
    pop_s       = done_s && op_store_r;
    push_s      = core_memwrite && (!full_s || pop_s);
    // A load already answered last cycle must not be re-issued.
    load_req_s  = core_memread && !load_done_r && !match_s;
    if (core_memwrite) begin
      core_stall_s = !push_s;
    end else if (core_memread) begin
      core_stall_s = !load_done_r;
    end else begin
      core_stall_s = 1'b0;
    end
  end

  // Mem FSM next state and op selection.
  always_comb begin
    state_next_s = state_r;
    sel_load_s   = 1'b0;
    sel_store_s  = 1'b0;
    case (state_r)
      M_IDLE: begin
        if (mem_stall) begin
          state_next_s = M_IDLE;
        end else if (load_req_s) begin
          sel_load_s   = 1'b1;
          state_next_s = M_ISSUE;
        end else if (count_s != {(PTR_W + 1){1'b0}}) begin
          sel_store_s  = 1'b1;
          state_next_s = M_ISSUE;
        end else begin
          state_next_s = M_IDLE;
        end
      end
      M_ISSUE: state_next_s = M_WAIT;
      M_WAIT: begin
        if (done_s) begin
          state_next_s = M_IDLE;
        end else begin
          state_next_s = M_WAIT;
        end
      end
      default: state_next_s = M_IDLE;
    endcase
  end

  // FSM state, registered mem-side request fields and load result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= M_IDLE;
      op_store_r      <= 1'b0;
      seen_stall_r    <= 1'b0;
      load_done_r     <= 1'b0;
      mem_addr_r      <= 32'h0000_0000;
      mem_wdata_r     <= 32'h0000_0000;
      mem_sign_mask_r <= 4'h0;
      mem_memwrite_r  <= 1'b0;
      mem_memread_r   <= 1'b0;
      core_rdata_r    <= 32'h0000_0000;
    end else begin
      state_r        <= state_next_s;
      mem_memwrite_r <= sel_store_s;
      mem_memread_r  <= sel_load_s;
      if (sel_load_s) begin
        mem_addr_r      <= core_addr;
        mem_wdata_r     <= 32'h0000_0000;
        mem_sign_mask_r <= core_sign_mask;
        op_store_r      <= 1'b0;
      end else if (sel_store_s) begin
        mem_addr_r      <= head_s.addr;
        mem_wdata_r     <= head_s.wdata;
        mem_sign_mask_r <= head_s.sign_mask;
        op_store_r      <= 1'b1;
      end
      // The stall high phase may start during M_ISSUE, so count it there too.
      if ((state_r == M_IDLE) || done_s) begin
        seen_stall_r <= 1'b0;
      end else begin
        seen_stall_r <= seen_stall_r | mem_stall;
      end
      load_done_r <= done_s && !op_store_r;
      if (done_s && !op_store_r) begin
        core_rdata_r <= mem_rdata;
      end
    end
  end

  assign core_stall    = core_stall_s;
  assign core_rdata    = core_rdata_r;
  assign mem_addr      = mem_addr_r;
  assign mem_wdata     = mem_wdata_r;
  assign mem_sign_mask = mem_sign_mask_r;
  assign mem_memwrite  = mem_memwrite_r;
  assign mem_memread   = mem_memread_r;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a table of isolated transactions plus
// hand-written multi-cycle sequences, against a small data memory model.
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_memwrite, core_memread, core_stall;
  logic [3:0]  core_sign_mask;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_memwrite, mem_memread, mem_stall;
  logic [3:0]  mem_sign_mask;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_memwrite(core_memwrite), .core_memread(core_memread),
    .core_sign_mask(core_sign_mask), .core_rdata(core_rdata), .core_stall(core_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_memwrite(mem_memwrite),
    .mem_memread(mem_memread), .mem_sign_mask(mem_sign_mask),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall)
  );

  // ---------------- data memory model ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } op_t;

  op_t         log_q[$];
  logic [31:0] mem_model [0:4095];
  int          stall_len = 3;
  int          stall_cnt = 0;
  logic        preload = 1'b0;
  logic        prev_strobe = 1'b0;
  logic        busy = 1'b0;
  logic [31:0] lat_addr, lat_wdata;
  logic [3:0]  lat_mask;
  int          pulse_err = 0, stable_err = 0, both_err = 0;

  assign mem_stall = (stall_cnt != 0);

  always @(posedge clk) begin
    prev_strobe <= mem_memwrite | mem_memread;
    if ((mem_memwrite | mem_memread) && prev_strobe) pulse_err <= pulse_err + 1;
    if (mem_memwrite && mem_memread) both_err <= both_err + 1;
    if (preload) mem_model[12'h480] <= 32'hCAFE_F00D;
    if (mem_memwrite || mem_memread) begin
      log_q.push_back(op_t'{mem_memwrite, mem_addr, mem_wdata, mem_sign_mask});
      stall_cnt <= stall_len;
      if (mem_memwrite) mem_model[mem_addr[13:2]] <= mem_wdata;
      else mem_rdata <= mem_model[mem_addr[13:2]];
      busy      <= 1'b1;
      lat_addr  <= mem_addr;
      lat_wdata <= mem_wdata;
      lat_mask  <= mem_sign_mask;
    end else begin
      if (stall_cnt != 0) stall_cnt <= stall_cnt - 1;
      if (!rst_n) begin
        busy <= 1'b0;
      end else if (busy) begin
        if (mem_addr != lat_addr || mem_wdata != lat_wdata || mem_sign_mask != lat_mask)
          stable_err <= stable_err + 1;
        if (stall_cnt == 0) busy <= 1'b0;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                          output int n);
    @(negedge clk);
    core_addr = a; core_wdata = d; core_sign_mask = m; core_memwrite = 1'b1;
    #1;
    n = 0;
    while (core_stall && n < 100) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1;
    core_memwrite = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [3:0] m,
                         output logic [31:0] d, output int n);
    @(negedge clk);
    core_addr = a; core_sign_mask = m; core_memread = 1'b1;
    #1;
    n = 0;
    while (core_stall && n < 100) begin @(negedge clk); #1; n++; end
    d = core_rdata;
    @(posedge clk); #1;
    core_memread = 1'b0;
  endtask

  task automatic wait_log(input int target);
    int k;
    k = 0;
    while (log_q.size() < target && k < 300) begin @(negedge clk); k++; end
    repeat (12) @(negedge clk);
  endtask

  task automatic check_entry(input string name, input int idx, input logic we,
                             input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    if (idx >= log_q.size()) begin
      check({name, "_present"}, 32'(log_q.size()), 32'(idx + 1));
    end else begin
      check({name, "_we"},   {31'd0, log_q[idx].we}, {31'd0, we});
      check({name, "_addr"}, log_q[idx].addr, a);
      if (we) check({name, "_data"}, log_q[idx].wdata, d);
      check({name, "_mask"}, {28'd0, log_q[idx].mask}, {28'd0, m});
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        is_load;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    int          stall;
    int          exp_wait;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base;
    logic [31:0] d;

    vecs[0] = '{"st_1004",    1'b0, 32'h0000_1004, 32'hDEAD_BEEF, SM_WORD, 3, 0, 32'h0};
    vecs[1] = '{"ld_1004",    1'b1, 32'h0000_1004, 32'h0,         SM_WORD, 3, 6, 32'hDEAD_BEEF};
    vecs[2] = '{"st_led",     1'b0, 32'h0000_2000, 32'h0000_00FF, SM_BYTE, 1, 0, 32'h0};
    vecs[3] = '{"ld_led",     1'b1, 32'h0000_2000, 32'h0,         SM_BYTE, 1, 4, 32'h0000_00FF};
    vecs[4] = '{"ld_preload", 1'b1, 32'h0000_1200, 32'h0,         SM_WORD, 2, 5, 32'hCAFE_F00D};
    vecs[5] = '{"st_1300",    1'b0, 32'h0000_1300, 32'h0BAD_F00D, SM_HALF, 1, 0, 32'h0};
    vecs[6] = '{"ld_1302",    1'b1, 32'h0000_1302, 32'h0,         SM_HALF, 4, 7, 32'h0BAD_F00D};

    rst_n = 1'b0; preload = 1'b1;
    core_addr = 32'h0; core_wdata = 32'h0; core_sign_mask = 4'h0;
    core_memwrite = 1'b0; core_memread = 1'b0;
    repeat (3) @(negedge clk);
    preload = 1'b0;
    check("rst_core_stall", {31'd0, core_stall}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_strobes", {30'd0, mem_memwrite, mem_memread}, 32'h0);
    check("rst_core_rdata", core_rdata, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Isolated transactions from an idle buffer.
    for (int i = 0; i < 7; i++) begin
      stall_len = vecs[i].stall;
      base = log_q.size();
      if (vecs[i].is_load) begin
        do_load(vecs[i].addr, vecs[i].mask, d, n);
        check({vecs[i].name, "_wait"}, 32'(n), 32'(vecs[i].exp_wait));
        check({vecs[i].name, "_rdata"}, d, vecs[i].exp_rdata);
      end else begin
        do_store(vecs[i].addr, vecs[i].wdata, vecs[i].mask, n);
        check({vecs[i].name, "_wait"}, 32'(n), 32'(vecs[i].exp_wait));
      end
      wait_log(base + 1);
      check({vecs[i].name, "_ops"}, 32'(log_q.size()), 32'(base + 1));
      check_entry(vecs[i].name, base, !vecs[i].is_load, vecs[i].addr, vecs[i].wdata, vecs[i].mask);
    end

    // Five back-to-back stores: the fifth waits for the first pop.
    stall_len = 3;
    base = log_q.size();
    for (int i = 0; i < 5; i++) begin
      do_store(32'h0000_1000 + 32'(4 * i), 32'h1111_0000 + 32'(i), SM_WORD, n);
      check($sformatf("b2b_wait%0d", i), 32'(n), (i == 4) ? 32'd2 : 32'd0);
    end
    wait_log(base + 5);
    check("b2b_ops", 32'(log_q.size()), 32'(base + 5));
    for (int i = 0; i < 5; i++)
      check_entry($sformatf("b2b%0d", i), base + i, 1'b1, 32'h0000_1000 + 32'(4 * i),
                  32'h1111_0000 + 32'(i), SM_WORD);

    // Load hitting a just-posted store waits for the drain.
    base = log_q.size();
    do_store(32'h0000_1008, 32'h1234_5678, SM_WORD, n);
    do_load(32'h0000_100A, SM_WORD, d, n);
    check("hazard_wait", 32'(n), 32'd12);
    check("hazard_rdata", d, 32'h1234_5678);
    wait_log(base + 2);
    check_entry("hazard_st", base, 1'b1, 32'h0000_1008, 32'h1234_5678, SM_WORD);
    check_entry("hazard_ld", base + 1, 1'b0, 32'h0000_100A, 32'h0, SM_WORD);

    // Non-matching load bypasses the second pending store.
    base = log_q.size();
    do_store(32'h0000_1100, 32'hAAAA_0001, SM_WORD, n);
    do_store(32'h0000_1104, 32'hAAAA_0002, SM_WORD, n);
    do_load(32'h0000_1200, SM_WORD, d, n);
    check("bypass_wait", 32'(n), 32'd11);
    check("bypass_rdata", d, 32'hCAFE_F00D);
    wait_log(base + 3);
    check_entry("bypass_st0", base, 1'b1, 32'h0000_1100, 32'hAAAA_0001, SM_WORD);
    check_entry("bypass_ld", base + 1, 1'b0, 32'h0000_1200, 32'h0, SM_WORD);
    check_entry("bypass_st1", base + 2, 1'b1, 32'h0000_1104, 32'hAAAA_0002, SM_WORD);

    // Reset while a drain is in M_WAIT with three entries queued.
    do_store(32'h0000_1400, 32'hBBBB_0000, SM_WORD, n);
    do_store(32'h0000_1404, 32'hBBBB_0001, SM_WORD, n);
    do_store(32'h0000_1408, 32'hBBBB_0002, SM_WORD, n);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    base = log_q.size();
    check("mrst_core_stall", {31'd0, core_stall}, 32'h0);
    check("mrst_strobes", {30'd0, mem_memwrite, mem_memread}, 32'h0);
    check("mrst_mem_addr", mem_addr, 32'h0);
    check("mrst_mem_wdata", mem_wdata, 32'h0);
    check("mrst_mem_mask", {28'd0, mem_sign_mask}, 32'h0);
    check("mrst_core_rdata", core_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("mrst_no_strobes", 32'(log_q.size()), 32'(base));
    do_load(32'h0000_1408, SM_WORD, d, n);
    check("mrst_load_wait", 32'(n), 32'd6);
    wait_log(base + 1);

    // Ten stores with the FIFO near full; pointers wrap twice.
    stall_len = 2;
    base = log_q.size();
    for (int i = 0; i < 10; i++)
      do_store(32'h0000_3000 + 32'(4 * i), 32'hA500_0000 + 32'(i),
               (i % 3 == 0) ? SM_BYTE : ((i % 3 == 1) ? SM_HALF : SM_WORD), n);
    wait_log(base + 10);
    check("wrap_ops", 32'(log_q.size()), 32'(base + 10));
    for (int i = 0; i < 10; i++)
      check_entry($sformatf("wrap%0d", i), base + i, 1'b1, 32'h0000_3000 + 32'(4 * i),
                  32'hA500_0000 + 32'(i),
                  (i % 3 == 0) ? SM_BYTE : ((i % 3 == 1) ? SM_HALF : SM_WORD));

    check("strobe_single_cycle", 32'(pulse_err), 32'd0);
    check("strobe_exclusive", 32'(both_err), 32'd0);
    check("mem_fields_stable", 32'(stable_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
